// File: rtl/sat_acc_pkg.sv
// Shared types and the clamp rule for the saturating accumulator family.
// Also used by the PID output stage, so widths are carried at SAT_MAX_W bits.
package sat_acc_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_N_CH       = 2;
  localparam int DEF_LEAK_SHIFT = 4;
  localparam int SAT_MAX_W      = 64;

  typedef struct packed {
    logic hi;
    logic lo;
  } sat_flags_t;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] value;
    sat_flags_t                  flags;
  } sat_result_t;

  // An inverted window (lim_lo > lim_hi) always resolves to lim_hi.
  function automatic sat_result_t sat_clamp_f(
    input logic signed [SAT_MAX_W:0]   sum,
    input logic signed [SAT_MAX_W-1:0] lim_hi,
    input logic signed [SAT_MAX_W-1:0] lim_lo
  );
    sat_result_t r;
    r.flags = '0;
    if (lim_lo > lim_hi || sum > lim_hi) begin
      r.value    = lim_hi;
      r.flags.hi = 1'b1;
    end else if (sum < lim_lo) begin
      r.value    = lim_lo;
      r.flags.lo = 1'b1;
    end else begin
      r.value = sum[SAT_MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational clamp of an (ACC_WIDTH+1)-bit signed sum into ACC_WIDTH bits
// against a signed [lim_lo, lim_hi] window.
module sat_clamp import sat_acc_pkg::*; #(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic signed [ACC_WIDTH:0]   sum,
  input  logic signed [ACC_WIDTH-1:0] lim_hi,
  input  logic signed [ACC_WIDTH-1:0] lim_lo,
  output logic signed [ACC_WIDTH-1:0] value,
  output sat_flags_t                  flags
);

  sat_result_t res;
  logic        unused_res_hi;

  always_comb begin
    res = sat_clamp_f((SAT_MAX_W+1)'(sum), SAT_MAX_W'(lim_hi), SAT_MAX_W'(lim_lo));
  end

  // The result always lies inside the window, so the upper bits are redundant.
  assign value         = res.value[ACC_WIDTH-1:0];
  assign flags         = res.flags;
  assign unused_res_hi = ^res.value[SAT_MAX_W-1:ACC_WIDTH];

endmodule

// File: rtl/sat_accumulator_mc.sv
// Multi-channel signed saturating accumulator (PID integrator), two-stage pipeline.
// Define SAT_ACC_LEAK_EN to turn each update into a leaky integrator.
module sat_accumulator_mc import sat_acc_pkg::*; #(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter  int N_CH       = DEF_N_CH,
  parameter  int LEAK_SHIFT = DEF_LEAK_SHIFT,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic signed [ACC_WIDTH-1:0]  lim_hi_i,
  input  logic signed [ACC_WIDTH-1:0]  lim_lo_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH_W-1:0]              in_ch,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_W-1:0]              out_ch,
  output logic signed [ACC_WIDTH-1:0]  out_acc,
  output logic                         out_sat_hi,
  output logic                         out_sat_lo,
  output logic [N_CH-1:0]              sat_sticky
);

  localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

  logic signed [ACC_WIDTH-1:0] acc [N_CH];
  logic                        s1_valid;
  logic [CH_W-1:0]             s1_ch;
  logic signed [ACC_WIDTH-1:0] s1_data;
  logic                        s2_adv;
  logic                        ch_ok;
  logic signed [ACC_WIDTH-1:0] acc_rd;
  logic signed [ACC_WIDTH:0]   acc_ext;
  logic signed [ACC_WIDTH:0]   data_ext;
  logic signed [ACC_WIDTH:0]   sum;
  logic signed [ACC_WIDTH-1:0] clamp_val;
  sat_flags_t                  clamp_flags;

  assign s2_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !clear_i && (!s1_valid || s2_adv);
  assign ch_ok    = {1'b0, in_ch} < N_CH_L;

  // Read and write of acc[ch] both live in S2, so same-channel samples never race.
  assign acc_rd   = acc[s1_ch];
  assign acc_ext  = (ACC_WIDTH+1)'(acc_rd);
  assign data_ext = (ACC_WIDTH+1)'(s1_data);

`ifdef SAT_ACC_LEAK_EN
  assign sum = acc_ext - (acc_ext >>> LEAK_SHIFT) + data_ext;
`else
  localparam int leak_shift_unused = LEAK_SHIFT;
  assign sum = acc_ext + data_ext;
`endif

  sat_clamp #(.ACC_WIDTH(ACC_WIDTH)) u_clamp (
    .sum    (sum),
    .lim_hi (lim_hi_i),
    .lim_lo (lim_lo_i),
    .value  (clamp_val),
    .flags  (clamp_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      s1_valid   <= 1'b0;
      s1_ch      <= '0;
      s1_data    <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_acc    <= '0;
      out_sat_hi <= 1'b0;
      out_sat_lo <= 1'b0;
      sat_sticky <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      sat_sticky <= '0;
    end else begin
      // Samples for non-existent channels are accepted but never enter S1.
      if (in_valid && in_ready) begin
        s1_valid <= ch_ok;
        s1_ch    <= in_ch;
        s1_data  <= ACC_WIDTH'(in_data);
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_adv) begin
        acc[s1_ch]        <= clamp_val;
        out_ch            <= s1_ch;
        out_acc           <= clamp_val;
        out_sat_hi        <= clamp_flags.hi;
        out_sat_lo        <= clamp_flags.lo;
        sat_sticky[s1_ch] <= sat_sticky[s1_ch] | clamp_flags.hi | clamp_flags.lo;
        out_valid         <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sat_accumulator_mc.sv
// Bench for sat_accumulator_mc: directed steps plus random traffic, scored against
// an arithmetic per-channel model of the clamped running sums.
module tb_sat_accumulator_mc;

  localparam int DW  = 16;
  localparam int AW  = 24;
  localparam int NCH = 2;
  localparam int CHW = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear_i = 1'b0;
  logic signed [AW-1:0] lim_hi_i = 24'sd1000;
  logic signed [AW-1:0] lim_lo_i = -24'sd1000;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CHW-1:0]       in_ch = '0;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [CHW-1:0]       out_ch;
  logic signed [AW-1:0] out_acc;
  logic                 out_sat_hi;
  logic                 out_sat_lo;
  logic [NCH-1:0]       sat_sticky;

  sat_accumulator_mc #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .N_CH(NCH), .LEAK_SHIFT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
    .lim_hi_i(lim_hi_i), .lim_lo_i(lim_lo_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_acc(out_acc),
    .out_sat_hi(out_sat_hi), .out_sat_lo(out_sat_lo), .sat_sticky(sat_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    longint acc;
    bit     hi;
    bit     lo;
    int     sticky;
  } exp_t;

  longint modelAcc [NCH];
  int     modelSticky;
  exp_t   expQ [$];
  int     testsRun = 0;
  int     testsFailed = 0;
  bit     lastAccepted;

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NCH; i++) modelAcc[i] = 0;
    modelSticky = 0;
    expQ.delete();
  endtask

  // Each update is the clamped running sum (optionally decayed) of that channel.
  task automatic modelAccept(input int ch, input longint data);
    longint s, hi, lo;
    exp_t   e;
    hi = longint'(lim_hi_i);
    lo = longint'(lim_lo_i);
`ifdef SAT_ACC_LEAK_EN
    s = modelAcc[ch] - (modelAcc[ch] >>> 4) + data;
`else
    s = modelAcc[ch] + data;
`endif
    e.hi = 1'b0;
    e.lo = 1'b0;
    if (lo > hi || s > hi) begin
      s = hi;
      e.hi = 1'b1;
    end else if (s < lo) begin
      s = lo;
      e.lo = 1'b1;
    end
    modelAcc[ch] = s;
    if (e.hi || e.lo) modelSticky = modelSticky | (1 << ch);
    e.ch     = ch;
    e.acc    = s;
    e.sticky = modelSticky;
    expQ.push_back(e);
  endtask

  // One clock: observe handshakes mid-cycle, score outputs, then update the model.
  task automatic tick();
    bit     inAcc, outAcc, doClear;
    int     capCh;
    longint capData;
    exp_t   e;
    @(negedge clk);
    inAcc   = rst_n && in_valid && in_ready;
    outAcc  = rst_n && out_valid && out_ready;
    doClear = rst_n && clear_i;
    capCh   = int'(in_ch);
    capData = longint'(in_data);
    if (outAcc) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_ch", out_ch, e.ch);
        checkOutput("out_acc", out_acc, e.acc);
        checkOutput("out_sat_hi", out_sat_hi, e.hi);
        checkOutput("out_sat_lo", out_sat_lo, e.lo);
        checkOutput("sat_sticky", sat_sticky, e.sticky);
      end
    end
    @(posedge clk);
    #1;
    lastAccepted = inAcc && !doClear;
    if (doClear) resetModel();
    else if (inAcc) modelAccept(capCh, capData);
  endtask

  task automatic applyStimulus(input int ch, input int data);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_ch    = CHW'(ch);
    in_data  = DW'(data);
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      done = lastAccepted;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  task automatic pulseClear();
    in_valid = 1'b0;
    clear_i  = 1'b1;
    #1;
    checkOutput("clear_in_ready", in_ready, 0);
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    int sent;
    resetModel();

    #12;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_acc", out_acc, 0);
    checkOutput("rst_sticky", sat_sticky, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, 100);
    checkOutput("lat_s1_empty_out", out_valid, 0);
    idle(1);
    checkOutput("lat_out_valid", out_valid, 1);
    applyStimulus(0, 200);
    applyStimulus(0, -50);
    drain();

    applyStimulus(1, 600);
    applyStimulus(1, 600);
    applyStimulus(1, -100);
    drain();
    checkOutput("pos_sticky", sat_sticky, modelSticky);
    applyStimulus(0, 300);
    drain();

    applyStimulus(0, -32768);
    drain();
    lim_lo_i = 24'sd5;
    lim_hi_i = 24'sd0;
    applyStimulus(1, 1);
    drain();
    checkOutput("prio_acc", out_acc, 0);
    checkOutput("prio_hi", out_sat_hi, 1);
    lim_hi_i = 24'sd1000;
    lim_lo_i = -24'sd1000;

    applyStimulus(0, 1500);
    drain();
    applyStimulus(0, 33);
    pulseClear();
    checkOutput("clear_out_valid", out_valid, 0);
    checkOutput("clear_sticky", sat_sticky, 0);
    idle(3);
    applyStimulus(0, 7);
    drain();

    pulseClear();
    in_valid  = 1'b1;
    in_ch     = '0;
    in_data   = 16'sd10;
    out_ready = 1'b0;
    sent      = 0;
    for (int c = 0; c < 12 && sent < 4; c++) begin
      if (c == 4) out_ready = 1'b1;
      tick();
      if (lastAccepted) sent++;
      if (c == 2 || c == 3) begin
        checkOutput("bp_in_ready", in_ready, 0);
        checkOutput("bp_out_valid", out_valid, 1);
        checkOutput("bp_hold", out_acc, expQ[0].acc);
      end
    end
    checkOutput("bp_sent", sent, 4);
    drain();

    applyStimulus(1, 400);
    applyStimulus(0, -900);
    applyStimulus(1, 700);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_out_acc", out_acc, 0);
    checkOutput("arst_sticky", sat_sticky, 0);
    resetModel();
    idle(2);
    rst_n = 1'b1;
    applyStimulus(1, 7);
    drain();

    for (int round = 0; round < 5; round++) begin
      if (round == 4) begin
        lim_hi_i = 24'sd8388607;
        lim_lo_i = -24'sd8388608;
      end else begin
        lim_hi_i = AW'(int'($urandom_range(0, 40000)) - 20000);
        lim_lo_i = AW'(int'($urandom_range(0, 40000)) - 20000);
      end
      for (int i = 0; i < 80; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_ch     = CHW'($urandom_range(0, NCH-1));
        in_data   = DW'(round == 4 ? 32767 : int'($urandom));
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      drain();
    end

`ifdef SAT_ACC_LEAK_EN
    lim_hi_i = 24'sd1000;
    lim_lo_i = -24'sd1000;
    pulseClear();
    applyStimulus(0, 800);
    drain();
    applyStimulus(0, 0);
    drain();
    checkOutput("leak_first", out_acc, 750);
    applyStimulus(0, 0);
    drain();
    checkOutput("leak_second", out_acc, 704);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
